// File: rtl/multdiv_unit.sv
// Iterative 32-bit multiply/divide unit for the execute stage: one shift-add or
// restoring-subtract step per cycle, with sign correction applied when the result is written.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ok,
    output logic             busy,
    output logic [1:0]       stateDbg
);

    // Handshake: execute raises valid with stable operands and holds it until ok.
    // An op is taken on the edge where valid && !flush in IDLE. ok is high for
    // exactly one cycle (DONE), and the hazard unit releases the stall in that cycle.
    // flush drops whatever is in flight and wins over a same-cycle valid.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam int CW = $clog2(STEPS) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    stateT state, nextState;

    logic             isDiv;
    logic             negRes;
    logic             negRem;
    logic             bZero;
    logic [WIDTH-1:0] origA;
    logic [WIDTH-1:0] magOp;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [CW-1:0]    count;

    logic             accept;
    logic             opSigned;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic               divGe;
    logic [WIDTH-1:0]   divDiff;
    logic [WIDTH-1:0]   nextHi;
    logic [WIDTH-1:0]   nextLo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   finHi;
    logic [WIDTH-1:0]   finLo;

    assign accept   = (state == IDLE) && valid && !flush;
    assign opSigned = !op[0];
    assign absA     = (opSigned && a[WIDTH-1]) ? -a : a;
    assign absB     = (opSigned && b[WIDTH-1]) ? -b : b;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (valid) nextState = BUSY;
            BUSY:    if (count == LAST_STEP) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (flush) nextState = IDLE;
    end

    assign ok       = (state == DONE);
    assign busy     = (state != IDLE);
    assign stateDbg = state;

    // One iteration step. Multiply keeps {accHi, accLo} as {partial product, multiplier};
    // divide keeps {remainder, dividend/quotient} and shifts quotient bits into accLo.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, magOp} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divGe    = divShift >= {1'b0, magOp};
        divDiff  = divShift[WIDTH-1:0] - magOp;
        if (isDiv) begin
            nextHi = divGe ? divDiff : divShift[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], divGe};
        end else begin
            nextHi = mulSum[WIDTH:1];
            nextLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
    end

    // Sign correction of the value produced by the final step
    always_comb begin
        prod  = {nextHi, nextLo};
        finHi = nextHi;
        finLo = nextLo;
        if (!isDiv) begin
            if (negRes) prod = -prod;
            finHi = prod[2*WIDTH-1:WIDTH];
            finLo = prod[WIDTH-1:0];
        end else if (bZero) begin
            finHi = origA;
            finLo = '1;
        end else begin
            if (negRes) finLo = -nextLo;
            if (negRem) finHi = -nextHi;
        end
    end

    // Datapath: operand capture, iteration and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            isDiv  <= 1'b0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            bZero  <= 1'b0;
            origA  <= '0;
            magOp  <= '0;
            accHi  <= '0;
            accLo  <= '0;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (accept) begin
            isDiv  <= op[1];
            negRes <= opSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
            negRem <= opSigned && op[1] && a[WIDTH-1];
            bZero  <= (b == '0);
            origA  <= a;
            magOp  <= op[1] ? absB : absA;
            accHi  <= '0;
            accLo  <= op[1] ? absA : absB;
            count  <= '0;
        end else if (state == BUSY) begin
            accHi <= nextHi;
            accLo <= nextLo;
            count <= count + 1'b1;
            if (count == LAST_STEP) begin
                hi <= finHi;
                lo <= finLo;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed corner ops, latency/handshake, flush and reset
// scenarios, then random ops scored against an arithmetic reference model.
module tb_multdiv_unit;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ok;
    logic        busy;
    logic [1:0]  stateDbg;

    int checks = 0;
    int errors = 0;
    logic [63:0] expQ[$];
    logic [63:0] lastRes;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    multdiv_unit dut (
        .clk(clk), .resetn(resetn), .valid(valid), .op(op), .a(a), .b(b),
        .flush(flush), .hi(hi), .lo(lo), .ok(ok), .busy(busy), .stateDbg(stateDbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] ma, mb, q, r;
        logic        sx, sy;
        case (o)
            MULTU: p = {32'b0, x} * {32'b0, y};
            MULT:  p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
            default: begin
                if (y == 32'b0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else begin
                    sx = (o == DIV) && x[31];
                    sy = (o == DIV) && y[31];
                    ma = sx ? -x : x;
                    mb = sy ? -y : y;
                    q  = ma / mb;
                    r  = ma % mb;
                    if (sx ^ sy) q = -q;
                    if (sx) r = -r;
                    p = {r, q};
                end
            end
        endcase
        return p;
    endfunction

    // Drives one op from the current cycle (cycle 0) until ok; lat is cycles to ok.
    // Operands are scrambled while the unit is busy since it must use its latched copies.
    task automatic doOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input bit holdValid, output int lat);
        logic [63:0] want;
        valid = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        expQ.push_back(exp);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (busy && !ok) begin
                a = $urandom;
                b = $urandom_range(0, 3);
            end
        end while (!ok && lat < 60);
        want = expQ.pop_front();
        check("result", {hi, lo}, want);
        lastRes = want;
        if (!holdValid) valid = 1'b0;
    endtask

    task automatic checkIdleAfter();
        @(posedge clk);
        #1;
        check("okOneCycle", {62'b0, ok, busy}, 64'd0);
    endtask

    logic [1:0]  dOp[9]  = '{MULTU, MULT, MULT, DIVU, DIV, DIV, DIV, DIVU, MULT};
    logic [31:0] dA[9]   = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9,
                             32'h8000_0000, 32'h1234_5678, 32'd9, 32'd7};
    logic [31:0] dB[9]   = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'd7, 32'd2,
                             32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [63:0] dExp[9] = '{64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000,
                             64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0002_0000_000E,
                             64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000,
                             64'h1234_5678_FFFF_FFFF, 64'h0000_0009_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFF9};

    initial begin
        int lat;
        bit sawOk;
        logic [1:0]  rOp;
        logic [31:0] rA, rB;

        // Reset
        resetn = 1'b1;
        valid  = 1'b0;
        flush  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        lastRes = '0;
        #2 resetn = 1'b0;
        #1;
        check("resetOutputs", {hi, lo}, 64'd0);
        check("resetStatus", {62'b0, ok, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Directed corner ops with full latency check
        for (int i = 0; i < 9; i++) begin
            doOp(dOp[i], dA[i], dB[i], dExp[i], 1'b0, lat);
            check("latency", 64'(lat), 64'd33);
            checkIdleAfter();
        end

        // Flush at cycle 10 of a DIVU, then a new op accepted at cycle 11
        valid = 1'b1;
        op    = DIVU;
        a     = 32'd1000;
        b     = 32'd3;
        sawOk = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (ok) sawOk = 1'b1;
        end
        flush = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flushNoOk", {62'b0, sawOk, ok}, 64'd0);
        check("flushBusy", {63'b0, busy}, 64'd0);
        check("flushHoldsResult", {hi, lo}, lastRes);
        doOp(MULTU, 32'd123456, 32'd789, 64'd97406784, 1'b0, lat);
        check("afterFlushLatency", 64'(lat), 64'd33);
        checkIdleAfter();

        // Flush and valid together in IDLE must not start an op
        valid = 1'b1;
        flush = 1'b1;
        op    = DIV;
        a     = 32'd50;
        b     = 32'd5;
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;
        check("flushBeatsValid", {63'b0, busy}, 64'd0);
        sawOk = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ok || busy) sawOk = 1'b1;
        end
        check("flushBeatsValidQuiet", {63'b0, sawOk}, 64'd0);

        // Back-to-back with valid held: ok at cycles 33 and 67
        doOp(MULTU, 32'd2, 32'd3, 64'h0000_0000_0000_0006, 1'b1, lat);
        check("b2bFirstLatency", 64'(lat), 64'd33);
        doOp(DIVU, 32'd9, 32'd4, 64'h0000_0001_0000_0002, 1'b0, lat);
        check("b2bSecondLatency", 64'(lat + 33), 64'd67);
        checkIdleAfter();

        // Reset pulsed mid-operation
        valid = 1'b1;
        op    = MULTU;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
        repeat (20) @(posedge clk);
        #1;
        resetn = 1'b0;
        valid  = 1'b0;
        #1;
        lastRes = '0;
        check("midResetOutputs", {hi, lo}, 64'd0);
        check("midResetStatus", {62'b0, ok, busy}, 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        sawOk = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ok) sawOk = 1'b1;
        end
        check("midResetNoOk", {63'b0, sawOk}, 64'd0);
        check("midResetHold", {hi, lo}, lastRes);

        // Random ops against the reference model
        for (int i = 0; i < 24; i++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = $urandom;
            case ($urandom_range(0, 3))
                0:       rB = 32'd0;
                1:       rB = $urandom_range(1, 20);
                2:       rB = -($urandom_range(1, 20));
                default: rB = $urandom;
            endcase
            doOp(rOp, rA, rB, refModel(rOp, rA, rB), 1'b0, lat);
            check("randLatency", 64'(lat), 64'd33);
            checkIdleAfter();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative multicycle multiply/divide unit.
- Instantiated inside the execute stage. Executes MULT, MULTU, DIV and DIVU.
- Drives the execute-side mult_ok signal to the hazard unit. Hazard stalls F/D/E while an op is in flight.
- The 64-bit {hi, lo} result travels down the execute data path to the HI/LO write request issued in writeback.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; results are 2*WIDTH bits.
- STEPS, 32, number of iteration cycles in BUSY. Must equal WIDTH.

Ports:
- clk  input  1  pipeline clock
- resetn  input  1  asynchronous active-low reset
- valid  input  1  execute holds a mult/div op; held high with stable operands until ok
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  32  rs value (dividend / multiplicand)
- b  input  32  rt value (divisor / multiplier)
- flush  input  1  flushE; aborts any op in flight
- hi  output  32  product[63:32] / remainder
- lo  output  32  product[31:0] / quotient
- ok  output  1  result valid this cycle; routed to hazard mult_ok
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock. resetn is asynchronous, active-low.
- Reset values: state=IDLE, hi=0, lo=0, ok=0, busy=0, iteration counter=0.
- FSM states and transitions:
  - IDLE→BUSY when valid && !flush.
  - On that edge: latch op and operand magnitudes, the sign flags, and the b==0 flag. Clear the accumulator. Counter=0.
  - BUSY: one shift-add step (multiply) or one restoring-subtract step (divide) per cycle. Counter increments.
  - BUSY→DONE after the STEPS-th step, i.e. when counter==STEPS-1 at the edge.
  - DONE→IDLE unconditionally on the next edge.
- Latency: accept edge at cycle 0; BUSY occupies cycles 1..32; ok=1 during cycle 33 only.
- ok is decoded from state==DONE. It is never high for more than one consecutive cycle.
- hi/lo registers:
  - Written on the BUSY→DONE edge with the sign-corrected result.
  - Hold their value at all other times, including across IDLE and flush.
- Handshake:
  - The stall releases in the ok cycle, so execute advances at the same edge the unit returns to IDLE.
  - If valid is high in IDLE on the cycle after DONE, it is a new op and is accepted normally.
  - Back-to-back ops therefore cost 34 cycles each.
- Operand changes while BUSY are ignored; the latched copies are used.
- Signed ops (MULT, DIV):
  - Operate on |a| and |b|.
  - Product is negated if sign(a)^sign(b).
  - Quotient is negated if sign(a)^sign(b). Remainder takes sign(a).
  - All arithmetic wraps mod 2^32 / 2^64.
  - Consequence: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (b==0, DIV or DIVU):
  - Timing unchanged (ok at cycle 33).
  - Result forced to hi=a (original, un-negated), lo=0xFFFFFFFF.
- Flush:
  - flush=1 in any state forces state=IDLE on the next edge. Accumulator and counter are discarded.
  - ok is not asserted for the aborted op; hi/lo are unchanged.
  - flush takes priority over a simultaneous valid in IDLE: no accept.
  - flush in the DONE cycle: ok is still 1 that cycle (combinational from state) and hi/lo are already updated. Execute/hazard discard the result.
- Reset mid-operation: immediate return to reset values, whatever the state.
- Exceptions flow through flushE; the unit has no other abort path.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, valid held → ok exactly at cycle 33, hi=0xFFFFFFFE lo=0x00000001; ok=0 at cycle 34, busy=0.
- MULT a=0x80000000 b=0x80000000 → hi=0x40000000 lo=0; MULT a=-3 b=5 → hi=0xFFFFFFFF lo=0xFFFFFFF1.
- DIVU a=100 b=7 → lo=14 hi=2; DIV a=-7 b=2 → lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000 hi=0.
- DIV a=0x12345678 b=0 → ok at cycle 33, hi=0x12345678 lo=0xFFFFFFFF.
- Flush at cycle 10 of a DIVU → no ok ever for that op, hi/lo unchanged, busy=0 at cycle 11; next op accepted at cycle 11 → ok at cycle 44 with correct result. Flush and valid together in IDLE → no accept.
- Back-to-back MULTU 2*3 then DIVU 9/4 with valid kept high → ok at cycles 33 and 67, results {0,6} then {hi=1,lo=2}. resetn pulsed low at cycle 20 of a third op → all outputs 0 immediately, no ok.
